// File: rtl/rfphoenix_opnd_stage_pkg.sv
// Shared types for the rfPhoenix operand-fetch stage: instruction/value words,
// register-field extraction and the operand bundle handed to the ALU.
package rfphoenix_opnd_stage_pkg;

  localparam int THREAD_W = 2;
  localparam int REG_W    = 6;

  typedef logic [31:0]         instruction_t;
  typedef logic [31:0]         value_t;
  typedef logic [REG_W-1:0]    regno_t;
  typedef logic [THREAD_W-1:0] thread_t;

  // Instruction layout: [5:0] opcode, [11:6] rt, [17:12] ra, [23:18] rb, [29:24] rc.
  function automatic regno_t fn_ra(input instruction_t ir);
    return ir[17:12];
  endfunction

  function automatic regno_t fn_rb(input instruction_t ir);
    return ir[23:18];
  endfunction

  function automatic regno_t fn_rc(input instruction_t ir);
    return ir[29:24];
  endfunction

  function automatic regno_t fn_rt(input instruction_t ir);
    return ir[11:6];
  endfunction

  typedef struct packed {
    instruction_t ir;
    thread_t      thread;
    value_t       a;
    value_t       b;
    value_t       c;
    value_t       t;
    value_t       imm;
  } opnd_t;

endpackage

// File: rtl/rfphoenix_opnd_stage_if.sv
// Decoder, register-file, writeback and ALU signals of the operand stage.
// slave is the stage itself; master is its environment.
interface rfphoenix_opnd_stage_if
  import rfphoenix_opnd_stage_pkg::*;
#(
  parameter int TW = THREAD_W,
  parameter int AW = REG_W
) ();

  logic          in_valid;
  logic          in_ready;
  instruction_t  in_ir;
  logic [TW-1:0] in_thread;
  value_t        in_imm;

  logic [TW-1:0] rf_thread;
  logic [AW-1:0] rf_ra, rf_rb, rf_rc, rf_rt;
  value_t        rf_a, rf_b, rf_c, rf_t;

  logic          wb_valid;
  logic [TW-1:0] wb_thread;
  logic [AW-1:0] wb_reg;
  value_t        wb_data;

  logic          out_valid;
  logic          out_ready;
  instruction_t  out_ir;
  logic [TW-1:0] out_thread;
  value_t        out_a, out_b, out_c, out_t, out_imm;

  modport slave (
    input  in_valid, in_ir, in_thread, in_imm,
    input  rf_a, rf_b, rf_c, rf_t,
    input  wb_valid, wb_thread, wb_reg, wb_data,
    input  out_ready,
    output in_ready, rf_thread, rf_ra, rf_rb, rf_rc, rf_rt,
    output out_valid, out_ir, out_thread, out_a, out_b, out_c, out_t, out_imm
  );

  modport master (
    output in_valid, in_ir, in_thread, in_imm,
    output rf_a, rf_b, rf_c, rf_t,
    output wb_valid, wb_thread, wb_reg, wb_data,
    output out_ready,
    input  in_ready, rf_thread, rf_ra, rf_rb, rf_rc, rf_rt,
    input  out_valid, out_ir, out_thread, out_a, out_b, out_c, out_t, out_imm
  );

endinterface

// File: rtl/rfphoenix_opnd_fwd.sv
// One-operand writeback forward mux; register 0 always yields zero.
module rfphoenix_opnd_fwd
  import rfphoenix_opnd_stage_pkg::*;
#(
  parameter int TW = THREAD_W,
  parameter int AW = REG_W
) (
  input  logic [AW-1:0] reg_no,
  input  logic [TW-1:0] thread,
  input  value_t        cand,
  input  logic          wb_valid,
  input  logic [TW-1:0] wb_thread,
  input  logic [AW-1:0] wb_reg,
  input  value_t        wb_data,
  output value_t        fwd_val
);

  always_comb begin
    fwd_val = cand;
    if (reg_no == '0) begin
      fwd_val = '0;
    end else if (wb_valid && (wb_thread == thread) && (wb_reg == reg_no)) begin
      fwd_val = wb_data;
    end
  end

endmodule

// File: rtl/rfphoenix_opnd_stage.sv
// Operand fetch: RD slot (register-file read / hold) feeding an OUT slot toward the ALU,
// with writeback forwarding into every operand that is waiting in either slot.
module rfphoenix_opnd_stage
  import rfphoenix_opnd_stage_pkg::*;
#(
  parameter int TW = THREAD_W,
  parameter int AW = REG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  rfphoenix_opnd_stage_if.slave bus
);

  typedef enum logic [1:0] {RD_EMPTY, RD_FETCH, RD_HELD} rd_state_e;

  rd_state_e     rd_state, rd_state_nxt;
  logic          out_valid_q, out_valid_nxt;
  logic          rd_valid, move, accept;

  instruction_t  rd_ir;
  logic [TW-1:0] rd_thread;
  value_t        rd_imm;
  value_t        hold    [4];
  value_t        rf_dat  [4];
  value_t        rd_cand [4];
  value_t        rd_val  [4];
  logic [AW-1:0] rd_reg  [4];

  opnd_t         out_q;
  value_t        out_opnd [4];
  value_t        out_fwd  [4];
  logic [AW-1:0] out_reg  [4];

  assign rd_valid     = (rd_state != RD_EMPTY);
  assign move         = rd_valid & (~out_valid_q | bus.out_ready);
  assign bus.in_ready = ~flush & (~rd_valid | ~out_valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  assign bus.rf_thread = bus.in_thread;
  assign bus.rf_ra     = fn_ra(bus.in_ir);
  assign bus.rf_rb     = fn_rb(bus.in_ir);
  assign bus.rf_rc     = fn_rc(bus.in_ir);
  assign bus.rf_rt     = fn_rt(bus.in_ir);

  assign rf_dat[0] = bus.rf_a;
  assign rf_dat[1] = bus.rf_b;
  assign rf_dat[2] = bus.rf_c;
  assign rf_dat[3] = bus.rf_t;
  assign rd_reg[0] = fn_ra(rd_ir);
  assign rd_reg[1] = fn_rb(rd_ir);
  assign rd_reg[2] = fn_rc(rd_ir);
  assign rd_reg[3] = fn_rt(rd_ir);

  assign out_opnd[0] = out_q.a;
  assign out_opnd[1] = out_q.b;
  assign out_opnd[2] = out_q.c;
  assign out_opnd[3] = out_q.t;
  assign out_reg[0]  = fn_ra(out_q.ir);
  assign out_reg[1]  = fn_rb(out_q.ir);
  assign out_reg[2]  = fn_rc(out_q.ir);
  assign out_reg[3]  = fn_rt(out_q.ir);

  for (genvar i = 0; i < 4; i++) begin : g_fwd
    // The register file is read-before-write, so the fetch cycle still needs forwarding.
    assign rd_cand[i] = (rd_state == RD_FETCH) ? rf_dat[i] : hold[i];

    rfphoenix_opnd_fwd #(.TW(TW), .AW(AW)) u_rd_fwd (
      .reg_no   (rd_reg[i]),
      .thread   (rd_thread),
      .cand     (rd_cand[i]),
      .wb_valid (bus.wb_valid),
      .wb_thread(bus.wb_thread),
      .wb_reg   (bus.wb_reg),
      .wb_data  (bus.wb_data),
      .fwd_val  (rd_val[i])
    );

    rfphoenix_opnd_fwd #(.TW(TW), .AW(AW)) u_out_fwd (
      .reg_no   (out_reg[i]),
      .thread   (out_q.thread),
      .cand     (out_opnd[i]),
      .wb_valid (bus.wb_valid),
      .wb_thread(bus.wb_thread),
      .wb_reg   (bus.wb_reg),
      .wb_data  (bus.wb_data),
      .fwd_val  (out_fwd[i])
    );
  end

  always_comb begin
    rd_state_nxt  = rd_state;
    out_valid_nxt = out_valid_q;
    if (flush) begin
      rd_state_nxt  = RD_EMPTY;
      out_valid_nxt = 1'b0;
    end else begin
      if (accept)                    rd_state_nxt = RD_FETCH;
      else if (move)                 rd_state_nxt = RD_EMPTY;
      else if (rd_state == RD_FETCH) rd_state_nxt = RD_HELD;

      if (move)               out_valid_nxt = 1'b1;
      else if (bus.out_ready) out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state    <= RD_EMPTY;
      out_valid_q <= 1'b0;
    end else begin
      rd_state    <= rd_state_nxt;
      out_valid_q <= out_valid_nxt;
    end
  end

  // Hold and OUT registers re-capture their forwarded value every cycle they stay put.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ir     <= '0;
      rd_thread <= '0;
      rd_imm    <= '0;
      hold      <= '{default: '0};
      out_q     <= '0;
    end else begin
      if (accept) begin
        rd_ir     <= bus.in_ir;
        rd_thread <= bus.in_thread;
        rd_imm    <= bus.in_imm;
      end
      hold <= rd_val;
      if (move) begin
        out_q <= '{ir: rd_ir, thread: rd_thread, a: rd_val[0], b: rd_val[1],
                   c: rd_val[2], t: rd_val[3], imm: rd_imm};
      end else begin
        out_q.a <= out_fwd[0];
        out_q.b <= out_fwd[1];
        out_q.c <= out_fwd[2];
        out_q.t <= out_fwd[3];
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_ir     = out_q.ir;
  assign bus.out_thread = out_q.thread;
  assign bus.out_a      = out_q.a;
  assign bus.out_b      = out_q.b;
  assign bus.out_c      = out_q.c;
  assign bus.out_t      = out_q.t;
  assign bus.out_imm    = out_q.imm;

endmodule

// File: tb/tb_rfphoenix_opnd_stage.sv
// Directed and random stimulus for the operand stage, checked against a queue-based
// model: the stage holds at most two instructions in order and refreshes waiting operands.
module tb_rfphoenix_opnd_stage;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  rfphoenix_opnd_stage_if bus ();

  rfphoenix_opnd_stage dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0]      ir;
    logic [1:0]       th;
    logic [31:0]      imm;
    logic [3:0][5:0]  r;       // [0]=ra [1]=rb [2]=rc [3]=rt
    logic [3:0][31:0] v;
    logic             fetched;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  bit   head_vis;
  bit   chk_en;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] resolve(input logic [5:0] r, input logic [1:0] th,
                                          input logic [31:0] cand);
    if (r == 6'd0) return 32'h0;
    if (bus.wb_valid && bus.wb_thread == th && bus.wb_reg == r) return bus.wb_data;
    return cand;
  endfunction

  task automatic offer(input logic [5:0] ra, input logic [5:0] rb, input logic [5:0] rc,
                       input logic [5:0] rt, input logic [1:0] th);
    cur.r       = {rt, rc, rb, ra};
    cur.th      = th;
    cur.imm     = $urandom();
    cur.ir      = {2'($urandom_range(0, 3)), rc, rb, ra, rt, 6'($urandom_range(0, 63))};
    cur.v       = '0;
    cur.fetched = 1'b0;
    bus.in_ir     = cur.ir;
    bus.in_thread = th;
    bus.in_imm    = cur.imm;
    bus.in_valid  = 1'b1;
  endtask

  task automatic set_rf(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] t);
    bus.rf_a = a; bus.rf_b = b; bus.rf_c = c; bus.rf_t = t;
  endtask

  task automatic set_wb(input logic v, input logic [1:0] th, input logic [5:0] r,
                        input logic [31:0] d);
    bus.wb_valid = v; bus.wb_thread = th; bus.wb_reg = r; bus.wb_data = d;
  endtask

  // Check the current cycle against the model, then advance model and DUT by one edge.
  task automatic cycle();
    logic             exp_rdy;
    logic [3:0][31:0] rfv;
    ent_t             e;
    @(negedge clk);
    exp_rdy = !flush && (q.size() < 2 || bus.out_ready);
    if (chk_en) begin
      chk("in_ready", bus.in_ready, exp_rdy);
      chk("out_valid", bus.out_valid, head_vis);
      chk("rf_thread", bus.rf_thread, cur.th);
      chk("rf_ra", bus.rf_ra, cur.r[0]);
      chk("rf_rt", bus.rf_rt, cur.r[3]);
      if (head_vis) begin
        chk("out_ir", bus.out_ir, q[0].ir);
        chk("out_thread", bus.out_thread, q[0].th);
        chk("out_a", bus.out_a, q[0].v[0]);
        chk("out_b", bus.out_b, q[0].v[1]);
        chk("out_c", bus.out_c, q[0].v[2]);
        chk("out_t", bus.out_t, q[0].v[3]);
        chk("out_imm", bus.out_imm, q[0].imm);
      end
    end
    if (rst || flush) begin
      q.delete();
      head_vis = 1'b0;
    end else begin
      rfv = {bus.rf_t, bus.rf_c, bus.rf_b, bus.rf_a};
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        for (int k = 0; k < 4; k++)
          e.v[k] = resolve(e.r[k], e.th, e.fetched ? e.v[k] : rfv[k]);
        e.fetched = 1'b1;
        q[i] = e;
      end
      if (head_vis && bus.out_ready) begin
        void'(q.pop_front());
        head_vis = 1'b0;
      end
      if (q.size() > 0) head_vis = 1'b1;
      if (bus.in_valid && exp_rdy) q.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; chk_en = 1'b0; head_vis = 1'b0;
    cur = '0;
    bus.in_valid = 1'b0; bus.in_ir = '0; bus.in_thread = '0; bus.in_imm = '0;
    bus.out_ready = 1'b1;
    set_rf(0, 0, 0, 0);
    set_wb(0, 0, 0, 0);
    cycle();
    cycle();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_a", bus.out_a, 32'h0);
    chk("rst_out_imm", bus.out_imm, 32'h0);
    chk("rst_out_ir", bus.out_ir, 32'h0);

    // Back-to-back stream, a=r1=5, b=r2=7
    set_rf(32'd5, 32'd7, 32'h0, 32'h0);
    for (int n = 0; n < 4; n++) begin
      offer(6'd1, 6'd2, 6'd0, 6'd0, 2'd0);
      cycle();
      if (n == 1) begin
        chk("stream_first_valid", bus.out_valid, 1'b1);
        chk("stream_first_a", bus.out_a, 32'd5);
        chk("stream_first_b", bus.out_b, 32'd7);
      end
    end
    bus.in_valid = 1'b0;
    repeat (3) cycle();

    // Read/write collision in the fetch cycle, same thread then other thread
    offer(6'd3, 6'd0, 6'd0, 6'd0, 2'd1);
    cycle();
    bus.in_valid = 1'b0;
    set_rf(32'h1111, 32'h0, 32'h0, 32'h0);
    set_wb(1'b1, 2'd1, 6'd3, 32'hDEAD);
    cycle();
    set_wb(0, 0, 0, 0);
    chk("coll_same_thread", bus.out_a, 32'hDEAD);
    cycle();
    offer(6'd3, 6'd0, 6'd0, 6'd0, 2'd1);
    cycle();
    bus.in_valid = 1'b0;
    set_rf(32'h1111, 32'h0, 32'h0, 32'h0);
    set_wb(1'b1, 2'd2, 6'd3, 32'hDEAD);
    cycle();
    set_wb(0, 0, 0, 0);
    chk("coll_other_thread", bus.out_a, 32'h1111);
    cycle();

    // Stall coherence: both slots hold r4, writeback during the stall
    offer(6'd4, 6'd1, 6'd0, 6'd0, 2'd1);
    cycle();
    bus.out_ready = 1'b0;
    offer(6'd4, 6'd2, 6'd0, 6'd0, 2'd1);
    set_rf(32'h100, 32'h101, 32'h102, 32'h103);
    cycle();
    offer(6'd4, 6'd3, 6'd0, 6'd0, 2'd1);
    set_rf(32'h200, 32'h201, 32'h202, 32'h203);
    chk("stall_in_ready", bus.in_ready, 1'b0);
    cycle();
    set_rf($urandom(), $urandom(), $urandom(), $urandom());
    cycle();
    set_wb(1'b1, 2'd1, 6'd4, 32'h42);
    cycle();
    set_wb(0, 0, 0, 0);
    chk("stall_out_fwd", bus.out_a, 32'h42);
    chk("stall_in_ready_late", bus.in_ready, 1'b0);
    cycle();
    cycle();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("stall_release_a1", bus.out_a, 32'h42);
    cycle();
    chk("stall_release_v2", bus.out_valid, 1'b1);
    chk("stall_release_a2", bus.out_a, 32'h42);
    cycle();
    cycle();

    // Register 0 reads zero even with all-ones data and a writeback to r0
    offer(6'd0, 6'd0, 6'd5, 6'd6, 2'd2);
    cycle();
    bus.in_valid = 1'b0;
    set_rf(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_wb(1'b1, 2'd2, 6'd0, 32'h1234);
    cycle();
    set_wb(0, 0, 0, 0);
    chk("r0_a", bus.out_a, 32'h0);
    chk("r0_b", bus.out_b, 32'h0);
    cycle();

    // Flush with both slots full and an instruction on offer
    bus.out_ready = 1'b0;
    offer(6'd1, 6'd2, 6'd3, 6'd4, 2'd0);
    cycle();
    offer(6'd2, 6'd3, 6'd4, 6'd1, 2'd0);
    cycle();
    flush = 1'b1;
    offer(6'd3, 6'd3, 6'd3, 6'd3, 2'd3);
    cycle();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    offer(6'd1, 6'd1, 6'd2, 6'd2, 2'd3);
    set_rf(32'hA, 32'hB, 32'hC, 32'hD);
    cycle();
    bus.in_valid = 1'b0;
    chk("flush_lat_edge1", bus.out_valid, 1'b0);
    cycle();
    chk("flush_lat_edge2", bus.out_valid, 1'b1);
    chk("flush_lat_a", bus.out_a, 32'hA);
    cycle();

    // Reset under back-pressure
    bus.out_ready = 1'b0;
    offer(6'd1, 6'd2, 6'd3, 6'd4, 2'd1);
    cycle();
    offer(6'd4, 6'd3, 6'd2, 6'd1, 2'd1);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b1);
    chk("mid_rst_out_a", bus.out_a, 32'h0);
    chk("mid_rst_out_imm", bus.out_imm, 32'h0);
    cycle();
    bus.out_ready = 1'b1;

    // Random traffic with frequent register/thread collisions
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 7)
        offer(6'($urandom_range(0, 4)), 6'($urandom_range(0, 4)), 6'($urandom_range(0, 4)),
              6'($urandom_range(0, 4)), 2'($urandom_range(0, 1)));
      else
        bus.in_valid = 1'b0;
      set_rf($urandom(), $urandom(), $urandom(), $urandom());
      set_wb(1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 6'($urandom_range(0, 4)),
             $urandom());
      bus.out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 29) == 0);
      cycle();
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_wb(0, 0, 0, 0);
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rfphoenix_opnd_stage.md
# rfphoenix_opnd_stage

Operand-fetch stage for the rfPhoenix integer/FP pipeline. It accepts a decoded instruction from the decoder, reads four operands (a, b, c, t) from the synchronous-read register file, and forwards in-flight writeback data. It holds the result in a pipeline register with a valid/ready handshake toward the ALU stage, which consumes ir, a, b, c, t and imm. The stage sustains one instruction per cycle and holds operands without loss under ALU back-pressure.

## Interface

Parameters:
- TW, 2: thread-id width.
- AW, 6: register-number width (register 0 always reads zero).

Ports:
- clk  input  1  core clock.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- flush  input  1  kill all valid instructions in the stage.
- in_valid  input  1  decoder offers an instruction.
- in_ready  output  1  stage accepts this cycle.
- in_ir  input  Instruction  decoded instruction.
- in_thread  input  TW  thread id.
- in_imm  input  Value  extended immediate.
- rf_thread  output  TW  register-file read thread (combinational from in_thread).
- rf_ra, rf_rb, rf_rc, rf_rt  output  AW each  read addresses (combinational from in_ir).
- rf_a, rf_b, rf_c, rf_t  input  Value each  read data, valid the cycle after address.
- wb_valid  input  1  register-file write this cycle.
- wb_thread  input  TW  write thread.
- wb_reg  input  AW  write register.
- wb_data  input  Value  write data.
- out_valid  output  1  operands valid for ALU.
- out_ready  input  1  ALU accepts.
- out_ir  output  Instruction  to ALU.
- out_thread  output  TW  to ALU.
- out_a, out_b, out_c, out_t, out_imm  output  Value each  to ALU.

## Operation

- Two internal slots:
  - RD slot: instruction whose register-file read is in flight or whose data is held.
  - OUT slot: drives the ALU.
- RD slot states:
  - EMPTY.
  - FETCH: register-file data arrives this cycle.
  - HELD: data captured in hold registers because OUT could not advance.
- Transitions:
  - Acceptance: EMPTY→FETCH.
  - FETCH→HELD when OUT is full and out_ready=0.
  - FETCH/HELD→EMPTY on move to OUT, or →FETCH if a new instruction is accepted in the same cycle.
- Moves: RD moves to OUT when RD is valid and (~out_valid | out_ready).
- in_ready = ~flush & (~rd_valid | ~out_valid | out_ready). Acceptance requires in_valid & in_ready.
- Operand source in FETCH: rf_* data, except that a matching writeback (wb_valid, wb_thread==thread, wb_reg==operand reg, reg≠0) substitutes wb_data. The register file is read-before-write.
- Operand source in HELD and in OUT while out_valid & ~out_ready: the held value, replaced by wb_data on any matching writeback. This keeps stalled operands coherent.
- Register 0 yields 32'h0 regardless of rf data or writeback.
- Each operand matches independently; several operands may match the same writeback.
- imm, ir and thread are captured at acceptance and carried unchanged.
- flush: clears RD and OUT valid at the next edge and blocks acceptance that cycle; data registers are not cleared. If flush and rst are both asserted, rst governs (identical effect).

## Timing

- Reset values: out_valid=0, RD=EMPTY, in_ready=1 in the cycle after reset; all data outputs 0.
- Latency: accept at edge E0 → out_valid=1 after E1 (2 edges), with no stalls.
- Throughput: one instruction per cycle when out_ready is held at 1.
- out_* data is stable while out_valid & ~out_ready, except for forwarded-writeback updates.
- Back-pressure: with out_ready=0 and OUT full, one more instruction is accepted (it enters RD and then HELD), after which in_ready=0. No data is lost.
- Forwarding decision and capture use wb_* sampled in the same cycle. No multi-cycle lookahead.

## Structure

- Shared package (rfPhoenixPkg) holds Instruction and Value, plus new items:
  - Regno typedef (AW bits).
  - Field-extract functions fnRa/fnRb/fnRc/fnRt(Instruction).
  - Operand-bundle struct {ir, thread, a, b, c, t, imm}.
- Sub-module rfphoenix_opnd_fwd: one-operand forward mux (reg, thread, candidate value, wb_*) → value with reg-0 zeroing. It is instantiated for each operand in RD and OUT.
- Estimated size: ~200 lines of RTL.

## Test plan

- Reset then stream: rf returns a=5, b=7 for r1, r2; 4 back-to-back instructions, out_ready=1 → out_valid from cycle 2, one per cycle, operands correct, in_ready stays 1.
- Read-write collision: wb_valid with r3=32'hDEAD in the FETCH cycle, rf_a=32'h1111 for Ra=r3 → out_a=32'hDEAD. The same case on another thread → out_a=32'h1111.
- Stall coherence: out_ready=0 for 5 cycles with instructions in OUT and HELD, then wb r4=32'h42 matching both → both deliver 32'h42 after release, in order, and in_ready=0 during the stall.
- Register 0: Ra=Rb=0, rf data 32'hFFFF_FFFF and wb to r0 → out_a=out_b=0.
- Flush mid-stall: OUT and RD full, flush=1 with in_valid=1 → next cycle out_valid=0, nothing accepted, and the following instruction flows with 2-cycle latency.
- Reset mid-operation: rst during back-pressure → all outputs at reset values the next cycle, with no spurious out_valid.
